// File: rtl/wisc_isa_pkg.sv
// wisc_isa_pkg: WISC opcodes, format and immediate-range classes, encoder FSM state.
package wisc_isa_pkg;
  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_SIIC  = 5'b00010;
  localparam logic [4:0] OP_RTI   = 5'b00011;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_BLTZ  = 5'b01110;
  localparam logic [4:0] OP_BGEZ  = 5'b01111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_ROLI  = 5'b10100;
  localparam logic [4:0] OP_SLLI  = 5'b10101;
  localparam logic [4:0] OP_RORI  = 5'b10110;
  localparam logic [4:0] OP_SRLI  = 5'b10111;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_BTR   = 5'b11001;
  localparam logic [4:0] OP_SHF   = 5'b11010;
  localparam logic [4:0] OP_ALU   = 5'b11011;
  localparam logic [4:0] OP_SEQ   = 5'b11100;
  localparam logic [4:0] OP_SLT   = 5'b11101;
  localparam logic [4:0] OP_SLE   = 5'b11110;
  localparam logic [4:0] OP_SCO   = 5'b11111;

  typedef enum logic [2:0] {FMT_I1, FMT_R, FMT_I2, FMT_J, FMT_NONE} fmt_e;
  typedef enum logic [2:0] {RNG_S5, RNG_U5, RNG_U4, RNG_S8, RNG_U8, RNG_S11, RNG_NONE} rng_e;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_WR1, S_WR2, S_DONE} state_e;

  function automatic fmt_e op_fmt(input logic [4:0] op);
    case (op)
      OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI,
      OP_ST, OP_LD, OP_STU: return FMT_I1;
      OP_BTR, OP_SHF, OP_ALU, OP_SEQ, OP_SLT, OP_SLE, OP_SCO: return FMT_R;
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ, OP_JR, OP_JALR, OP_LBI, OP_SLBI: return FMT_I2;
      OP_J, OP_JAL: return FMT_J;
      default: return FMT_NONE;
    endcase
  endfunction

  function automatic rng_e op_rng(input logic [4:0] op);
    case (op)
      OP_ADDI, OP_SUBI, OP_ST, OP_LD, OP_STU: return RNG_S5;
      OP_XORI, OP_ANDNI: return RNG_U5;
      OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: return RNG_U4;
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ, OP_JR, OP_JALR, OP_LBI: return RNG_S8;
      OP_SLBI: return RNG_U8;
      OP_J, OP_JAL: return RNG_S11;
      default: return RNG_NONE;
    endcase
  endfunction

  function automatic logic in_range(input rng_e r, input logic [15:0] imm);
    logic signed [15:0] v;
    v = imm;
    case (r)
      RNG_S5: return v >= -16'sd16 && v <= 16'sd15;
      RNG_U5: return v >= 16'sd0 && v <= 16'sd31;
      RNG_U4: return v >= 16'sd0 && v <= 16'sd15;
      RNG_S8: return v >= -16'sd128 && v <= 16'sd127;
      RNG_U8: return v >= 16'sd0 && v <= 16'sd255;
      RNG_S11: return v >= -16'sd1024 && v <= 16'sd1023;
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/wisc_instr_encoder_if.sv
// wisc_instr_encoder_if: request handshake and instruction-memory write port.
interface wisc_instr_encoder_if;
  logic req_valid;
  logic req_ready;
  logic [4:0] req_opcode;
  logic [1:0] req_mode;
  logic req_li;
  logic [2:0] req_rs;
  logic [2:0] req_rt;
  logic [2:0] req_rd;
  logic [15:0] req_imm;
  logic mem_wr_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_wr_data;
  logic mem_ready;
  modport master (
    output req_valid, req_opcode, req_mode, req_li, req_rs, req_rt, req_rd, req_imm, mem_ready,
    input req_ready, mem_wr_en, mem_addr, mem_wr_data
  );
  modport slave (
    input req_valid, req_opcode, req_mode, req_li, req_rs, req_rt, req_rd, req_imm, mem_ready,
    output req_ready, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/wisc_instr_fmt.sv
// wisc_instr_fmt: packs one request into its instruction word(s) and range-checks the immediate.
module wisc_instr_fmt
  import wisc_isa_pkg::*;
(
    input  logic        li,
    input  logic [4:0]  opcode,
    input  logic [1:0]  mode,
    input  logic [2:0]  rs,
    input  logic [2:0]  rt,
    input  logic [2:0]  rd,
    input  logic [15:0] imm,
    output logic [15:0] word,
    output logic [15:0] word2,
    output logic        two,
    output logic        legal
);
    fmt_e fmt;
    logic [2:0] ra;
    logic short_li;
    logic [15:0] op_word;
    assign fmt = op_fmt(opcode);
    // LBI/SLBI carry their destination in the rs slot
    assign ra = (opcode == OP_LBI || opcode == OP_SLBI) ? rd : rs;
    assign short_li = in_range(RNG_S8, imm);
    always_comb begin
        case (fmt)
            FMT_I1:  op_word = {opcode, rs, rd, imm[4:0]};
            FMT_R:   op_word = {opcode, rs, rt, rd, mode};
            FMT_I2:  op_word = {opcode, ra, imm[7:0]};
            FMT_J:   op_word = {opcode, imm[10:0]};
            default: op_word = {opcode, 11'b0};
        endcase
    end
    assign word  = li ? {OP_LBI, rd, short_li ? imm[7:0] : imm[15:8]} : op_word;
    assign word2 = {OP_SLBI, rd, imm[7:0]};
    assign two   = li && !short_li;
    assign legal = li || in_range(op_rng(opcode), imm);
endmodule

// File: rtl/wisc_instr_encoder.sv
// wisc_instr_encoder: accepts instruction requests and writes the encoded words
// sequentially into instruction memory.
module wisc_instr_encoder
  import wisc_isa_pkg::*;
#(
    parameter logic [15:0] RESET_BASE = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [15:0]          base_addr,
    wisc_instr_encoder_if.slave  bus,
    output logic                 err,
    output logic                 done
);
    state_e state;
    logic [15:0] word, word2, word2_q;
    logic two, two_q, legal, halt;

    wisc_instr_fmt u_fmt (
        .li(bus.req_li),
        .opcode(bus.req_opcode),
        .mode(bus.req_mode),
        .rs(bus.req_rs),
        .rt(bus.req_rt),
        .rd(bus.req_rd),
        .imm(bus.req_imm),
        .word(word),
        .word2(word2),
        .two(two),
        .legal(legal)
    );

    assign halt = bus.mem_wr_data[15:11] == OP_HALT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            bus.mem_addr    <= RESET_BASE;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_wr_data <= 16'h0000;
            bus.req_ready   <= 1'b0;
            word2_q         <= 16'h0000;
            two_q           <= 1'b0;
            err             <= 1'b0;
            done            <= 1'b0;
        end else begin
            err <= 1'b0;
            // start outranks any write handshake in the same cycle
            if (start) begin
                state         <= S_RUN;
                bus.mem_addr  <= base_addr & 16'hFFFE;
                bus.mem_wr_en <= 1'b0;
                bus.req_ready <= 1'b1;
                two_q         <= 1'b0;
                done          <= 1'b0;
            end else begin
                case (state)
                    S_RUN: if (bus.req_valid) begin
                        if (legal) begin
                            state           <= S_WR1;
                            bus.mem_wr_en   <= 1'b1;
                            bus.mem_wr_data <= word;
                            bus.req_ready   <= 1'b0;
                            word2_q         <= word2;
                            two_q           <= two;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    S_WR1: if (bus.mem_ready) begin
                        bus.mem_addr <= bus.mem_addr + 16'd2;
                        if (two_q) begin
                            state           <= S_WR2;
                            bus.mem_wr_data <= word2_q;
                            two_q           <= 1'b0;
                        end else begin
                            state         <= halt ? S_DONE : S_RUN;
                            bus.mem_wr_en <= 1'b0;
                            bus.req_ready <= !halt;
                            done          <= halt;
                        end
                    end
                    S_WR2: if (bus.mem_ready) begin
                        state         <= S_RUN;
                        bus.mem_addr  <= bus.mem_addr + 16'd2;
                        bus.mem_wr_en <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wisc_instr_encoder.sv
// tb_wisc_instr_encoder: vector table, randomized requests against a table-driven ISA model,
// and hand sequences for stalls, HALT wrap and reset mid-write.
module tb_wisc_instr_encoder;
    localparam logic [15:0] RB = 16'h0040;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    logic err, done;

    wisc_instr_encoder_if bus();

    wisc_instr_encoder #(.RESET_BASE(RB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .bus(bus), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic li; logic [4:0] op; logic [1:0] mode;
        logic [2:0] rs, rt, rd; logic [15:0] imm;
        int n; logic [15:0] w0, w1; logic e;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    logic [15:0] got_a[$], got_d[$], exp_a[$], exp_d[$];
    logic [15:0] m_addr;
    string fmt_tab[32];
    int lo_tab[32], hi_tab[32];
    vec_t vecs[$];

    always @(posedge clk)
        if (rst_n && bus.mem_wr_en && bus.mem_ready) begin
            got_a.push_back(bus.mem_addr);
            got_d.push_back(bus.mem_wr_data);
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tab(input int op, input string f, input int lo, input int hi);
        fmt_tab[op] = f; lo_tab[op] = lo; hi_tab[op] = hi;
    endtask

    function automatic void model(input logic li, input logic [4:0] op, input logic [1:0] mode,
                                  input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                                  input logic [15:0] imm, output int n, output logic [15:0] w0,
                                  output logic [15:0] w1, output logic e);
        int v;
        v = int'($signed(imm));
        n = 0; w0 = 0; w1 = 0; e = 0;
        if (li) begin
            if (v >= -128 && v <= 127) begin n = 1; w0 = {5'b11000, rd, imm[7:0]}; end
            else begin n = 2; w0 = {5'b11000, rd, imm[15:8]}; w1 = {5'b10010, rd, imm[7:0]}; end
        end else if (v < lo_tab[op] || v > hi_tab[op]) e = 1;
        else begin
            n = 1;
            if (fmt_tab[op] == "I1") w0 = {op, rs, rd, imm[4:0]};
            else if (fmt_tab[op] == "R") w0 = {op, rs, rt, rd, mode};
            else if (fmt_tab[op] == "I2") w0 = {op, rs, imm[7:0]};
            else if (fmt_tab[op] == "I2D") w0 = {op, rd, imm[7:0]};
            else if (fmt_tab[op] == "J") w0 = {op, imm[10:0]};
            else w0 = {op, 11'b0};
        end
    endfunction

    task automatic compare_writes(input string name);
        chk({name, " write count"}, got_a.size(), exp_a.size());
        while (got_a.size() > 0 && exp_a.size() > 0) begin
            chk({name, " addr"}, got_a.pop_front(), exp_a.pop_front());
            chk({name, " data"}, got_d.pop_front(), exp_d.pop_front());
        end
        got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic expect_words(input int n, input logic [15:0] w0, input logic [15:0] w1);
        if (n > 0) begin exp_a.push_back(m_addr); exp_d.push_back(w0); m_addr += 16'd2; end
        if (n > 1) begin exp_a.push_back(m_addr); exp_d.push_back(w1); m_addr += 16'd2; end
    endtask

    task automatic send(input logic li, input logic [4:0] op, input logic [1:0] mode,
                        input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                        input logic [15:0] imm);
        int k = 0;
        while (!bus.req_ready && k < 50) begin @(negedge clk); k++; end
        if (!bus.req_ready) chk("req_ready timeout", bus.req_ready, 1);
        bus.req_li = li; bus.req_opcode = op; bus.req_mode = mode;
        bus.req_rs = rs; bus.req_rt = rt; bus.req_rd = rd; bus.req_imm = imm;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (!(bus.req_ready || done) && k < 40) begin @(negedge clk); k++; end
        if (!(bus.req_ready || done)) chk({name, " idle timeout"}, 0, 1);
    endtask

    task automatic run_req(input string name, input vec_t v);
        expect_words(v.n, v.w0, v.w1);
        send(v.li, v.op, v.mode, v.rs, v.rt, v.rd, v.imm);
        chk({name, " err"}, err, v.e);
        if (v.e) begin
            @(negedge clk);
            chk({name, " err one cycle"}, err, 0);
        end else wait_idle(name);
        compare_writes(name);
        chk({name, " next addr"}, bus.mem_addr, m_addr);
    endtask

    task automatic do_start(input logic [15:0] b);
        @(negedge clk);
        start = 1'b1; base_addr = b;
        @(negedge clk);
        start = 1'b0;
        m_addr = b & 16'hFFFE;
        got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    function automatic vec_t mk(input logic li, input logic [4:0] op, input logic [1:0] mode,
                                input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                                input logic [15:0] imm, input int n, input logic [15:0] w0,
                                input logic [15:0] w1, input logic e);
        vec_t v;
        v.li = li; v.op = op; v.mode = mode; v.rs = rs; v.rt = rt; v.rd = rd; v.imm = imm;
        v.n = n; v.w0 = w0; v.w1 = w1; v.e = e;
        return v;
    endfunction

    initial begin
        vec_t v;
        logic [15:0] a0;
        for (int o = 0; o < 4; o++) tab(o, "N", -32768, 32767);
        tab(5'b00100, "J", -1024, 1023); tab(5'b00110, "J", -1024, 1023);
        tab(5'b00101, "I2", -128, 127);  tab(5'b00111, "I2", -128, 127);
        tab(5'b01000, "I1", -16, 15);    tab(5'b01001, "I1", -16, 15);
        tab(5'b01010, "I1", 0, 31);      tab(5'b01011, "I1", 0, 31);
        for (int o = 12; o < 16; o++) tab(o, "I2", -128, 127);
        tab(5'b10000, "I1", -16, 15); tab(5'b10001, "I1", -16, 15); tab(5'b10011, "I1", -16, 15);
        tab(5'b10010, "I2D", 0, 255); tab(5'b11000, "I2D", -128, 127);
        for (int o = 20; o < 24; o++) tab(o, "I1", 0, 15);
        for (int o = 25; o < 32; o++) tab(o, "R", -32768, 32767);

        vecs.push_back(mk(0, 5'b11011, 0, 1, 2, 3, 16'h0000, 1, 16'hD94C, 0, 0));
        vecs.push_back(mk(0, 5'b01000, 0, 1, 0, 2, 16'hFFFF, 1, 16'h415F, 0, 0));
        vecs.push_back(mk(0, 5'b01000, 0, 1, 0, 2, 16'h0010, 0, 0, 0, 1));
        vecs.push_back(mk(0, 5'b01000, 0, 1, 0, 2, 16'hFFF0, 1, 16'h4150, 0, 0));
        vecs.push_back(mk(1, 5'b00000, 0, 0, 0, 4, 16'h1234, 2, 16'hC412, 16'h9434, 0));
        vecs.push_back(mk(1, 5'b01000, 0, 0, 0, 4, 16'hFFFB, 1, 16'hC4FB, 0, 0));
        vecs.push_back(mk(1, 5'b11111, 0, 0, 0, 1, 16'h0080, 2, 16'hC100, 16'h9180, 0));
        vecs.push_back(mk(1, 5'b00000, 0, 0, 0, 1, 16'hFF80, 1, 16'hC180, 0, 0));
        vecs.push_back(mk(0, 5'b10100, 0, 1, 0, 2, 16'h000F, 1, 16'hA14F, 0, 0));
        vecs.push_back(mk(0, 5'b10100, 0, 1, 0, 2, 16'h0010, 0, 0, 0, 1));
        vecs.push_back(mk(0, 5'b01010, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 1));
        vecs.push_back(mk(0, 5'b01010, 0, 0, 0, 0, 16'h001F, 1, 16'h501F, 0, 0));
        vecs.push_back(mk(0, 5'b10010, 0, 5, 0, 3, 16'h00FF, 1, 16'h93FF, 0, 0));
        vecs.push_back(mk(0, 5'b10010, 0, 5, 0, 3, 16'hFFFF, 0, 0, 0, 1));
        vecs.push_back(mk(0, 5'b01100, 0, 2, 0, 0, 16'hFF80, 1, 16'h6280, 0, 0));
        vecs.push_back(mk(0, 5'b01100, 0, 2, 0, 0, 16'h0080, 0, 0, 0, 1));
        vecs.push_back(mk(0, 5'b00100, 0, 0, 0, 0, 16'hFC00, 1, 16'h2400, 0, 0));
        vecs.push_back(mk(0, 5'b00100, 0, 0, 0, 0, 16'h0400, 0, 0, 0, 1));
        vecs.push_back(mk(0, 5'b00111, 0, 7, 0, 0, 16'h007F, 1, 16'h3F7F, 0, 0));
        vecs.push_back(mk(0, 5'b00001, 0, 3, 3, 3, 16'hBEEF, 1, 16'h0800, 0, 0));
        vecs.push_back(mk(0, 5'b11110, 3, 7, 0, 5, 16'hFFFF, 1, 16'hF717, 0, 0));

        bus.req_valid = 0; bus.req_li = 0; bus.req_opcode = 0; bus.req_mode = 0;
        bus.req_rs = 0; bus.req_rt = 0; bus.req_rd = 0; bus.req_imm = 0; bus.mem_ready = 1;

        #12;
        chk("reset wr_en", bus.mem_wr_en, 0);
        chk("reset addr", bus.mem_addr, RB);
        chk("reset data", bus.mem_wr_data, 0);
        chk("reset ready", bus.req_ready, 0);
        chk("reset err", err, 0);
        chk("reset done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle ready", bus.req_ready, 0);

        do_start(16'h0101);
        chk("start ready", bus.req_ready, 1);
        chk("start addr", bus.mem_addr, 16'h0100);

        foreach (vecs[i]) run_req($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 80; i++) begin
            v.li = ($urandom_range(0, 5) == 0);
            v.op = 5'($urandom_range(1, 31));
            v.mode = 2'($urandom); v.rs = 3'($urandom); v.rt = 3'($urandom); v.rd = 3'($urandom);
            v.imm = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($signed(8'($urandom_range(0, 255))) >>> $urandom_range(0, 3));
            model(v.li, v.op, v.mode, v.rs, v.rt, v.rd, v.imm, v.n, v.w0, v.w1, v.e);
            run_req($sformatf("rand%0d op=%b li=%0d imm=%h", i, v.op, v.li, v.imm), v);
        end

        a0 = m_addr;
        bus.mem_ready = 1'b0;
        expect_words(1, 16'hD94C, 0);
        send(0, 5'b11011, 0, 1, 2, 3, 16'h0000);
        for (int c = 0; c < 3; c++) begin
            chk("stall wr_en", bus.mem_wr_en, 1);
            chk("stall addr", bus.mem_addr, a0);
            chk("stall data", bus.mem_wr_data, 16'hD94C);
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        wait_idle("stall");
        compare_writes("stall");
        chk("stall next addr", bus.mem_addr, m_addr);

        do_start(16'hFFFE);
        run_req("halt", mk(0, 5'b00000, 0, 0, 0, 0, 16'h1234, 1, 16'h0000, 0, 0));
        chk("halt wrap addr", bus.mem_addr, 16'h0000);
        chk("halt done", done, 1);
        chk("halt ready", bus.req_ready, 0);
        do_start(16'h0203);
        chk("restart done", done, 0);
        chk("restart ready", bus.req_ready, 1);
        chk("restart addr", bus.mem_addr, 16'h0202);

        a0 = m_addr;
        bus.mem_ready = 1'b0;
        expect_words(1, 16'hC412, 0);
        send(1, 5'b00000, 0, 0, 0, 4, 16'h1234);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk("wr2 wr_en", bus.mem_wr_en, 1);
        chk("wr2 data", bus.mem_wr_data, 16'h9434);
        chk("wr2 addr", bus.mem_addr, a0 + 16'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst wr_en", bus.mem_wr_en, 0);
        chk("async rst addr", bus.mem_addr, RB);
        chk("async rst data", bus.mem_wr_data, 0);
        chk("async rst ready", bus.req_ready, 0);
        chk("async rst done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("post rst ready", bus.req_ready, 0);
        chk("post rst wr_en", bus.mem_wr_en, 0);
        compare_writes("rst mid write");

        do_start(16'h0300);
        run_req("after rst", vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wisc_instr_encoder.md
# wisc_instr_encoder

Sequential instruction encoder and loader for the WISC 16-bit pipelined processor. It accepts abstract instruction requests (opcode, mode, register fields, 16-bit immediate) over a valid/ready handshake. Each request is packed into its architectural word format, and the immediate is range-checked for that format. The resulting word(s) are written sequentially into instruction memory. It sits between the test/boot sequencer and the instruction-memory write port, and is the producer of the words that the control decoder consumes.

## Interface
- `RESET_BASE`, default 16'h0000: write address loaded at reset.
- `clk` input 1: the single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse; loads the write address from `base_addr` and begins a program.
- `base_addr` input 16: start byte address; bit 0 is ignored and forced to 0.
- `req_valid` input 1: request present.
- `req_ready` output 1: encoder can accept a request this cycle.
- `req_opcode` input 5: architectural opcode, I[15:11].
- `req_mode` input 2: function field for R-format instructions.
- `req_li` input 1: pseudo-op "load 16-bit constant into rd"; when set, `req_opcode` is ignored.
- `req_rs`, `req_rt`, `req_rd` input 3 each: register fields.
- `req_imm` input 16: immediate or displacement, two's complement.
- `mem_wr_en` output 1: write request to instruction memory.
- `mem_addr` output 16: byte address of the write.
- `mem_wr_data` output 16: encoded instruction word.
- `mem_ready` input 1: memory accepts the write this cycle.
- `err` output 1: one-cycle pulse on a rejected request.
- `done` output 1: HALT has been written; level signal.

## Operation
- Formats:
  - I1 = {op, rs, rd, imm[4:0]}
  - R = {op, rs, rt, rd, mode}
  - I2 = {op, rs, imm[7:0]}
  - J = {op, imm[10:0]}
  - HALT/NOP/SIIC/RTI = {op, 11'b0}
- Format per opcode:
  - I1: ADDI, SUBI, XORI, ANDNI, ROLI, SLLI, RORI, SRLI, ST, LD, STU.
  - R: BTR, 11011, 11010, SEQ, SLT, SLE, SCO.
  - I2: BEQZ, BNEZ, BLTZ, BGEZ, JR, JALR.
  - I2 with rd in the rs slot: LBI, SLBI.
  - J: J, JAL.
- Immediate ranges:
  - ADDI, SUBI, ST, LD, STU: [-16, 15].
  - XORI, ANDNI: [0, 31].
  - Rotates and shifts: [0, 15].
  - Branches, JR, JALR, LBI: [-128, 127].
  - SLBI: [0, 255].
  - J, JAL: [-1024, 1023].
  - R-format and no-operand opcodes ignore `req_imm`.
- Rejection: an out-of-range immediate or an undefined opcode (10100–10111 are valid; everything outside the table is undefined) pulses `err`. No memory write occurs, the write address is unchanged, and the FSM stays in RUN.
- LI expansion:
  - If `req_imm` is in [-128, 127], the encoder emits one word: LBI rd, imm[7:0].
  - Otherwise it emits two words: LBI rd, imm[15:8], then SLBI rd, imm[7:0].
- FSM states:
  - IDLE: `req_ready`=0. On `start`, go to RUN.
  - RUN: `req_ready`=1. An accepted valid request with a legal encoding goes to WR1.
  - WR1: hold the first word until `mem_ready`. On acceptance: go to WR2 if a second word is pending; else go to DONE if the word is HALT; else return to RUN.
  - WR2: hold the SLBI word until `mem_ready`, then return to RUN.
  - DONE: `done`=1 and `req_ready`=0. On `start`, go to RUN.
- `start` from any state reloads the write address, discards any pending word(s), clears `done`, and enters RUN. In that cycle `start` takes priority over a `mem_ready` handshake.
- Address arithmetic: 16-bit, +2 per accepted write. 16'hFFFE wraps to 16'h0000 with no flag.

## Timing
- Reset values:
  - `mem_wr_en`=0, `mem_addr`=RESET_BASE, `mem_wr_data`=0.
  - `req_ready`=0, `err`=0, `done`=0.
  - State = IDLE.
- Reset is asynchronous and may arrive mid-write. The pending word is lost and the write address returns to RESET_BASE.
- Handshake and latency:
  - A request is accepted on a cycle where `req_valid` and `req_ready` are both high.
  - `mem_wr_en` rises the following cycle; all outputs are registered.
  - `mem_addr` and `mem_wr_data` are stable while `mem_wr_en`=1 and `mem_ready`=0.
  - The address increments on the cycle after the handshake.
- Throughput: one request per 2 cycles when `mem_ready` is held at 1, because `req_ready` is low in WR1/WR2. An LI expansion takes 3 cycles.
- `err` goes high the cycle after the rejected acceptance, for exactly one cycle.

## Structure
- The shared package `wisc_isa_pkg` holds:
  - the opcode constants (5-bit);
  - the format enum I1/R/I2/J/NONE;
  - the immediate-range enum S5/U5/U4/S8/U8/S11/NONE;
  - the FSM state typedef.
- Combinational sub-module `wisc_instr_fmt`: maps opcode, mode, fields and immediate to {word, legal}.
- The top level holds the FSM, the address counter, the second-word register and the output registers.

## Test plan
- ADD, opcode 11011, rs=1, rt=2, rd=3, mode=00, base 0x0100, `mem_ready`=1 → one write of 0xD94C at 0x0100; address then reads 0x0102.
- ADDI rs=1, rd=2, imm=-1 → 0x415F. ADDI with imm=16 → `err` pulse, no write, address unchanged.
- LI rd=4, imm=0x1234 → 0xC412 at A, then 0x9434 at A+2. LI with imm=-5 → a single word, 0xC4FB.
- `mem_ready` held low for 3 cycles during WR1 → `mem_wr_en`, `mem_addr` and `mem_wr_data` stay constant; exactly one write is counted.
- HALT written at 0xFFFE → address wraps to 0x0000, `done`=1, `req_ready`=0. A `start` pulse then returns to RUN at `base_addr`.
- `rst_n` asserted during WR2 → all outputs return to their reset values immediately, and state is IDLE.
